serial_logic_control: RTL and testbench
=======================================

// Module: serial_logic_control
// PURPOSE
//  Sequencer for the serial logic processor datapath (A/B shift registers, bitwise compute unit, router).
//  Converts operator Execute/LoadA/LoadB inputs into load strobes and a shift-enable burst of exactly WIDTH cycles.
//  Captures the function select (F) and routing select (R) at operation start and holds them stable for the whole burst.
//  Waits in HALT until Execute is released, so one press runs one operation.
// PARAMETERS
//  WIDTH    8    register width = number of shift cycles per operation (2..64)
// PORTS
//  Clk       in   1          system clock; all state updates on rising edge
//  Reset     in   1          synchronous reset, active-high
//  Execute   in   1          start request (level, already synchronised)
//  LoadA     in   1          load request for register A (level)
//  LoadB     in   1          load request for register B (level)
//  F_In      in   3          function select from switches
//  R_In      in   2          routing select from switches
//  Ld_A      out  1          parallel-load strobe to register A
//  Ld_B      out  1          parallel-load strobe to register B
//  Shift_En  out  1          shift enable to both registers
//  F_Sel     out  3          latched function select to compute unit
//  R_Sel     out  2          latched routing select to router
//  Busy      out  1          high whenever state != IDLE
//  Done      out  1          high in HALT (operation complete, awaiting Execute release)
// BEHAVIOUR
//  - Reset (sampled on Clk edge): state=IDLE, count=0, F_Sel=0, R_Sel=0.
//    All outputs are 0 in the cycle after reset. Reset overrides every other input, including mid-SHIFT.
//  - States: IDLE, SHIFT, HALT. State and count are registered; outputs decode combinationally from them (Moore).
//    Exception: Ld_A and Ld_B also depend on the inputs.
//  - IDLE:
//    * Ld_A=LoadA, Ld_B=LoadB, Shift_En=0.
//    * Execute=1 at an edge -> SHIFT, count<=0, F_Sel<=F_In, R_Sel<=R_In.
//    * Execute and LoadA/LoadB in the same cycle: the load is honoured at that edge; shifting starts the next cycle.
//  - SHIFT:
//    * Shift_En=1, Ld_A=Ld_B=0 (load requests ignored). count increments every cycle.
//    * When count==WIDTH-1 -> HALT.
//    * Shift_En is high for exactly WIDTH consecutive cycles, starting the cycle after Execute is sampled.
//  - HALT:
//    * Shift_En=0, Ld_A=Ld_B=0, Done=1.
//    * Execute=0 -> IDLE. Execute held high -> stay; never re-triggers.
//  - F_Sel/R_Sel change only on the IDLE->SHIFT edge.
//    Changes to F_In/R_In during SHIFT or HALT have no effect until the next start.
//  - count is $clog2(WIDTH) bits. It never wraps: it is cleared on entry to SHIFT and is don't-care outside SHIFT (held at last value).
//  - Execute low for a single cycle in HALT is sufficient to return to IDLE.
// STRUCTURE
//  - Package serial_logic_pkg: typedef enum logic [1:0] {IDLE, SHIFT, HALT} slc_state_t; localparam widths FW=3, RW=2.
//  - Sub-module shift_counter #(WIDTH) (Clk, Reset, Clear, En -> Last): clears on Clear, increments on En, Last = count==WIDTH-1.
//  - Top level holds the state register, select latches and output decode.
// TESTING
//  1. Reset=1 for 2 cycles with all inputs=1 -> all outputs 0, Busy=0 after release with Execute=0.
//  2. IDLE, LoadA=1 for 1 cycle, then LoadB=1 -> Ld_A then Ld_B each high exactly 1 cycle, Shift_En=0.
//  3. F_In=3'b010, R_In=2'b10, pulse Execute high and hold:
//     -> Shift_En high exactly 8 cycles, F_Sel=010, R_Sel=10 throughout.
//     F_In=111 mid-burst -> F_Sel unchanged.
//     Done=1 until Execute drops, then IDLE; no second burst.
//  4. Reset asserted at 4th shift cycle -> next cycle Shift_En=0, state IDLE, F_Sel=R_Sel=0.
//     A new Execute then gives a full 8-cycle burst.
//  5. Execute and LoadA high in the same IDLE cycle -> Ld_A=1 that cycle, 8-cycle Shift_En burst starts the next cycle.
//     LoadB=1 during SHIFT -> Ld_B stays 0.
//  6. WIDTH=4 instance -> Shift_En burst of exactly 4 cycles, Done asserted the cycle after the last shift.

Source files
------------

// File: rtl/serial_logic_control_pkg.sv
// Shared types and field widths for the serial logic processor sequencer.
package serial_logic_pkg;

   localparam int FW = 3;
   localparam int RW = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HALT  = 2'd2
   } slc_state_t;

endpackage

// File: rtl/serial_logic_control_if.sv
// Operator-side requests/selects and datapath-side strobes between the panel and the sequencer.
interface serial_logic_control_if;
   import serial_logic_pkg::*;

   logic          Execute;
   logic          LoadA;
   logic          LoadB;
   logic [FW-1:0] F_In;
   logic [RW-1:0] R_In;

   logic          Ld_A;
   logic          Ld_B;
   logic          Shift_En;
   logic [FW-1:0] F_Sel;
   logic [RW-1:0] R_Sel;
   logic          Busy;
   logic          Done;

   modport master (
      output Execute, LoadA, LoadB, F_In, R_In,
      input  Ld_A, Ld_B, Shift_En, F_Sel, R_Sel, Busy, Done
   );

   modport slave (
      input  Execute, LoadA, LoadB, F_In, R_In,
      output Ld_A, Ld_B, Shift_En, F_Sel, R_Sel, Busy, Done
   );

endinterface

// File: rtl/serial_logic_control_shift_counter.sv
// Shift-cycle counter: Clear wins over En; Last flags the final cycle of a burst.
// Stops incrementing when the controller stops enabling it, so it never wraps.
module shift_counter #(
   parameter int WIDTH = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Clear,
   input  logic En,
   output logic Last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (Clear) begin
         count_d = '0;
      end else if (En) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign Last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_logic_control.sv
// Sequencer: Execute starts a WIDTH-cycle Shift_En burst with latched F/R selects, then waits in HALT
// until Execute is released. Moore outputs, except the load strobes which pass LoadA/LoadB through in IDLE.
module serial_logic_control
   import serial_logic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   serial_logic_control_if.slave  bus
);

   slc_state_t    state_q;
   slc_state_t    state_d;
   logic [FW-1:0] f_sel_q;
   logic [FW-1:0] f_sel_d;
   logic [RW-1:0] r_sel_q;
   logic [RW-1:0] r_sel_d;

   logic cnt_clear;
   logic cnt_en;
   logic cnt_last;

   shift_counter #(
      .WIDTH (WIDTH)
   ) u_shift_counter (
      .Clk   (Clk),
      .Reset (Reset),
      .Clear (cnt_clear),
      .En    (cnt_en),
      .Last  (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      f_sel_d   = f_sel_q;
      r_sel_d   = r_sel_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.Execute) begin
               state_d   = SHIFT;
               cnt_clear = 1'b1;
               f_sel_d   = bus.F_In;
               r_sel_d   = bus.R_In;
            end
         end
         SHIFT: begin
            // Hold the count on the last cycle rather than letting it roll over.
            if (cnt_last) begin
               state_d = HALT;
            end else begin
               cnt_en = 1'b1;
            end
         end
         HALT: begin
            if (!bus.Execute) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         f_sel_q <= '0;
         r_sel_q <= '0;
      end else begin
         state_q <= state_d;
         f_sel_q <= f_sel_d;
         r_sel_q <= r_sel_d;
      end
   end

   // Loads are suppressed while Reset is asserted so no register is written during reset.
   assign bus.Ld_A     = (state_q == IDLE) && bus.LoadA && !Reset;
   assign bus.Ld_B     = (state_q == IDLE) && bus.LoadB && !Reset;
   assign bus.Shift_En = (state_q == SHIFT);
   assign bus.Busy     = (state_q != IDLE);
   assign bus.Done     = (state_q == HALT);
   assign bus.F_Sel    = f_sel_q;
   assign bus.R_Sel    = r_sel_q;

endmodule

// File: tb/tb_serial_logic_control.sv
// Bench for serial_logic_control: WIDTH=8 and WIDTH=4 instances driven identically, checked per cycle against a behavioural model.
module tb_serial_logic_control;

   logic clk;
   logic rst;
   logic execute;
   logic load_a;
   logic load_b;
   logic [2:0] f_in;
   logic [1:0] r_in;

   int n_tests = 0;
   int n_fail  = 0;

   serial_logic_control_if if8 ();
   serial_logic_control_if if4 ();

   assign if8.Execute = execute;
   assign if8.LoadA   = load_a;
   assign if8.LoadB   = load_b;
   assign if8.F_In    = f_in;
   assign if8.R_In    = r_in;
   assign if4.Execute = execute;
   assign if4.LoadA   = load_a;
   assign if4.LoadB   = load_b;
   assign if4.F_In    = f_in;
   assign if4.R_In    = r_in;

   serial_logic_control #(.WIDTH(8)) dut8 (.Clk(clk), .Reset(rst), .bus(if8));
   serial_logic_control #(.WIDTH(4)) dut4 (.Clk(clk), .Reset(rst), .bus(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] obs [2];
   assign obs[0] = {if8.Ld_A, if8.Ld_B, if8.Shift_En, if8.Busy, if8.Done, if8.F_Sel, if8.R_Sel};
   assign obs[1] = {if4.Ld_A, if4.Ld_B, if4.Shift_En, if4.Busy, if4.Done, if4.F_Sel, if4.R_Sel};

   // Model: number of shift cycles still owed, whether we are parked awaiting release, and the latched selects.
   int         m_width [2] = '{8, 4};
   int         m_rem   [2];
   bit         m_halt  [2];
   logic [2:0] m_fsel  [2];
   logic [1:0] m_rsel  [2];

   int burst8;
   int burst4;
   int ldb8;

   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rem[k]  = 0;
         m_halt[k] = 1'b0;
         m_fsel[k] = '0;
         m_rsel[k] = '0;
      end
   endtask

   task automatic cycle(input string tag);
      logic [9:0] e;
      bit         busy;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         busy = (m_rem[k] > 0) || m_halt[k];
         e = {(!busy && load_a && !rst), (!busy && load_b && !rst),
              (m_rem[k] > 0), busy, m_halt[k], m_fsel[k], m_rsel[k]};
         chk($sformatf("%s_w%0d", tag, m_width[k]), {6'd0, obs[k]}, {6'd0, e});
      end
      if (if8.Shift_En) burst8++;
      if (if4.Shift_En) burst4++;
      if (if8.Ld_B && if8.Shift_En) ldb8++;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_rem[k]  = 0;
            m_halt[k] = 1'b0;
            m_fsel[k] = '0;
            m_rsel[k] = '0;
         end else if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) m_halt[k] = 1'b1;
         end else if (m_halt[k]) begin
            if (!execute) m_halt[k] = 1'b0;
         end else if (execute) begin
            m_rem[k]  = m_width[k];
            m_fsel[k] = f_in;
            m_rsel[k] = r_in;
         end
      end
      #1;
   endtask

   initial begin
      // Reset with every input high: nothing may leak out.
      rst = 1'b1; execute = 1'b1; load_a = 1'b1; load_b = 1'b1; f_in = 3'b111; r_in = 2'b11;
      @(posedge clk);
      #1;
      model_reset();
      cycle("rst_hold");
      cycle("rst_hold");
      rst = 1'b0; execute = 1'b0; load_a = 1'b0; load_b = 1'b0; f_in = '0; r_in = '0;
      cycle("post_rst");

      load_a = 1'b1;
      cycle("ld_a");
      load_a = 1'b0; load_b = 1'b1;
      cycle("ld_b");
      load_b = 1'b0;
      cycle("ld_idle");

      // Execute held high throughout; F_In changes mid-burst.
      f_in = 3'b010; r_in = 2'b10; execute = 1'b1;
      burst8 = 0; burst4 = 0;
      cycle("exe_start");
      for (int i = 0; i < 4; i++) cycle("burst");
      chk("fsel_mid", {13'd0, if8.F_Sel}, 16'h0002);
      f_in = 3'b111; r_in = 2'b01;
      for (int i = 0; i < 10; i++) cycle("burst_hold");
      chk("burst8_len", 16'(burst8), 16'd8);
      chk("burst4_len", 16'(burst4), 16'd4);
      chk("fsel_end", {13'd0, if8.F_Sel}, 16'h0002);
      chk("rsel_end", {14'd0, if8.R_Sel}, 16'h0002);
      chk("done_held", {15'd0, if8.Done}, 16'h0001);
      execute = 1'b0;
      burst8 = 0;
      for (int i = 0; i < 4; i++) cycle("release");
      chk("no_retrigger", 16'(burst8), 16'd0);

      // Reset during the 4th shift cycle of the WIDTH=8 instance.
      execute = 1'b1;
      cycle("rst_mid_start");
      execute = 1'b0;
      for (int i = 0; i < 3; i++) cycle("rst_mid_shift");
      rst = 1'b1;
      cycle("rst_mid_4th");
      rst = 1'b0;
      cycle("rst_mid_after");
      chk("rst_mid_fsel", {13'd0, if8.F_Sel}, 16'h0000);
      execute = 1'b1;
      burst8 = 0;
      cycle("rerun_start");
      execute = 1'b0;
      for (int i = 0; i < 11; i++) cycle("rerun");
      chk("rerun_len", 16'(burst8), 16'd8);

      // Execute together with LoadA; LoadB during the burst is ignored.
      execute = 1'b1; load_a = 1'b1;
      burst8 = 0; ldb8 = 0;
      cycle("exe_lda");
      execute = 1'b0; load_a = 1'b0; load_b = 1'b1;
      for (int i = 0; i < 8; i++) cycle("ldb_in_shift");
      load_b = 1'b0;
      cycle("ldb_after");
      chk("exe_lda_len", 16'(burst8), 16'd8);
      chk("ldb_ignored", 16'(ldb8), 16'd0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 39) == 0);
         execute = ($urandom_range(0, 2) != 0);
         load_a  = 1'($urandom);
         load_b  = 1'($urandom);
         f_in    = 3'($urandom);
         r_in    = 2'($urandom);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
